uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
Message-level round-robin arbiter that lets NUM_REQ independent byte producers share a single UART byte transmitter. Each requester presents a valid/ready byte stream with a last flag. A grant is held for the whole message, so bytes from different requesters never interleave on the serial line. The block sits between the producers and the UART TX serializer's byte-level valid/ready input. A stall timeout releases a grant when its requester stops supplying bytes mid-message.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
DATA_WIDTH, 8, byte width of each requester stream
TIMEOUT_CYCLES, 4096, consecutive cycles in XFER with the granted req_valid low before the grant is forcibly released (must be >= 2)

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
req_valid  input  NUM_REQ  per-requester byte valid
req_data  input  NUM_REQ*DATA_WIDTH  per-requester byte; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
req_last  input  NUM_REQ  marks the final byte of a message; qualified by req_valid
req_ready  output  NUM_REQ  byte accepted from requester i when req_valid[i] & req_ready[i]
tx_data  output  DATA_WIDTH  byte to the UART serializer
tx_valid  output  1  byte valid to the serializer
tx_ready  input  1  serializer can accept a byte
grant  output  NUM_REQ  one-hot registered grant; all zero when idle
busy  output  1  high while in XFER
timeout_pulse  output  1  one-cycle pulse when a grant is released by timeout

Behaviour:
- Reset (synchronous, takes effect at the clock edge): state=IDLE, grant=0, busy=0, tx_valid=0, req_ready=0, timeout_pulse=0, rr pointer=0, stall counter=0.
- States: IDLE, XFER.
- IDLE:
  - If any req_valid is high, select the first index with req_valid set, scanning upward from the rr pointer with wrap modulo NUM_REQ.
  - Next edge: grant becomes one-hot on that index, busy=1, state=XFER.
  - If no req_valid is high, remain in IDLE.
  - Request-to-first-byte-offer latency is 1 cycle.
- XFER with granted index g:
  - Combinational passthrough: tx_data = req_data[g]; tx_valid = req_valid[g]; req_ready[g] = tx_ready. req_ready is 0 for every other index.
  - A transfer occurs on any cycle where tx_valid & tx_ready.
  - Transfer with req_last[g]=1: next edge sets grant=0, busy=0, state=IDLE, rr pointer=(g+1) mod NUM_REQ.
  - The earliest next grant is therefore 2 cycles after the last-byte transfer: one IDLE arbitration cycle, then the grant edge.
- Stall counter:
  - Counts cycles in XFER where req_valid[g]=0.
  - Clears on any transfer, and on entry to XFER.
  - Does not count while req_valid[g]=1 and tx_ready=0; a backpressured serializer is never a stall.
  - When the counter reaches TIMEOUT_CYCLES-1 with req_valid[g] still 0: next edge sets state=IDLE, grant=0, busy=0, rr pointer=(g+1) mod NUM_REQ, timeout_pulse=1 for exactly one cycle.
  - Counter width is $clog2(TIMEOUT_CYCLES)+1; saturation is not required because the release occurs first.
- Non-granted requesters: req_valid may rise at any time and is held pending without being accepted. No byte is ever dropped or duplicated on a non-timeout path.
- Simultaneous events:
  - A new req_valid on another index in the same cycle as the last-byte transfer: arbitration for it happens in the following IDLE cycle.
  - The same requester re-requesting immediately: it is served again only if no other index between the pointer and itself is valid.
- Reset mid-message: the grant is dropped at the reset edge and tx_valid=0 from then on. A partially sent message is abandoned; the serializer finishes any byte it has already accepted.
- The outputs tx_valid, tx_data and req_ready are combinational in XFER only. In IDLE, tx_valid=0 and all req_ready=0.

Test Plan:
- Req 0 sends 3 bytes 0x4F,0x6B,0x0A (last on 0x0A), serializer accepts one byte per 10 cycles -> tx sees exactly those bytes in order; grant=0001 from 1 cycle after req_valid until 1 cycle after the last accept; then busy=0.
- Req 1 and req 2 both assert 2-byte messages in the same IDLE cycle, pointer=0 -> req 1 is served fully first, then req 2; pointer ends at 3.
- Req 0 mid-message (byte 2 of 4) while req 3 asserts -> no req 3 byte appears until req 0's last byte; req_ready[3] stays 0 throughout.
- TIMEOUT_CYCLES=16; req 2 sends 1 byte without last, then drops valid -> after 16 stalled cycles grant clears, timeout_pulse is high for 1 cycle, and a pending req 3 is granted next.
- All 4 requesters continuously valid with 1-byte messages -> grant order 0,1,2,3,0,1 (pointer wraps); each grant lasts until its single accept.
- Reset asserted while req 1 is on byte 2 of 5, tx_ready held 1 -> at the reset edge grant=0, tx_valid=0, pointer=0; after reset is released with req 1 still valid, req 1 is re-granted with 1-cycle latency.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: message-level round-robin share of one UART byte sink; ports req_valid/req_data/req_last/req_ready in, tx_data/tx_valid/tx_ready out, grant/busy/timeout_pulse status
module uart_tx_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int DATA_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]            req_last,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [DATA_WIDTH-1:0]         tx_data,
  output logic                          tx_valid,
  input  logic                          tx_ready,
  output logic [NUM_REQ-1:0]            grant,
  output logic                          busy,
  output logic                          timeout_pulse
);
  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;
  typedef enum logic {IDLE, XFER} state_t;
  state_t             state_q;
  logic [IW-1:0]      ptr_q, g_q, sel_d, ptr_d;
  logic [IW:0]        idx;
  logic [CW-1:0]      cnt_q;
  logic [NUM_REQ-1:0] grant_q;
  logic               timeout_q, g_valid, fire, stall_out;
  always_comb begin
    sel_d = ptr_q;
    idx = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = {1'b0, ptr_q} + (IW+1)'(k);
      idx = idx >= (IW+1)'(NUM_REQ) ? idx - (IW+1)'(NUM_REQ) : idx;
      sel_d = req_valid[idx[IW-1:0]] ? idx[IW-1:0] : sel_d;
    end
  end
  assign g_valid       = req_valid[g_q];
  assign fire          = (state_q == XFER) && g_valid && tx_ready;
  assign stall_out     = !g_valid && cnt_q == CW'(TIMEOUT_CYCLES - 1);
  assign ptr_d         = g_q == IW'(NUM_REQ - 1) ? '0 : g_q + IW'(1);
  assign tx_valid      = (state_q == XFER) && g_valid;
  assign tx_data       = req_data[g_q*DATA_WIDTH +: DATA_WIDTH];
  assign req_ready     = grant_q & {NUM_REQ{tx_ready}};
  assign grant         = grant_q;
  assign busy          = state_q == XFER;
  assign timeout_pulse = timeout_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      g_q       <= '0;
      ptr_q     <= '0;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= 1'b0;
      if (state_q == IDLE) begin
        if (|req_valid) begin
          state_q <= XFER;
          grant_q <= NUM_REQ'(1) << sel_d;
          g_q     <= sel_d;
          cnt_q   <= '0;
        end
      end else if ((fire && req_last[g_q]) || stall_out) begin
        state_q   <= IDLE;
        grant_q   <= '0;
        ptr_q     <= ptr_d;
        cnt_q     <= '0;
        timeout_q <= stall_out;
      end else begin
        cnt_q <= fire ? '0 : g_valid ? cnt_q : cnt_q + CW'(1);
      end
    end
  end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: randomized and directed checks of uart_tx_arbiter against a message-order model
module tb_uart_tx_arbiter;
  localparam int N  = 4;
  localparam int DW = 8;
  localparam int TO = 16;
  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            tx_ready = 1'b0;
  logic [N-1:0]    req_valid = '0;
  logic [N-1:0]    req_last = '0;
  logic [N*DW-1:0] req_data = '0;
  logic [N-1:0]    req_ready, grant;
  logic [DW-1:0]   tx_data;
  logic            tx_valid, busy, timeout_pulse;
  int              passed = 0, total = 0, mptr = 0;
  logic [DW:0]     pq [N][$];
  logic [N+DW-1:0] obs [$], exp_q [$];
  logic            s_xfer, s_busy, s_tv, s_to;
  logic [N-1:0]    s_grant, s_ready;
  logic [DW-1:0]   s_data;

  uart_tx_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
    .req_ready(req_ready), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .grant(grant), .busy(busy), .timeout_pulse(timeout_pulse));

  always #5 clk = ~clk;

  // one cycle: producers present their queue heads, outputs are sampled mid-cycle, accepted bytes pop after the edge
  task automatic step();
    logic [N-1:0] acc;
    for (int i = 0; i < N; i++) begin
      if (pq[i].size() > 0) begin
        req_valid[i] = 1'b1;
        req_data[i*DW +: DW] = pq[i][0][DW-1:0];
        req_last[i] = pq[i][0][DW];
      end else begin
        req_valid[i] = 1'b0;
        req_data[i*DW +: DW] = '0;
        req_last[i] = 1'b0;
      end
    end
    #4;
    s_grant = grant;
    s_ready = req_ready;
    s_busy = busy;
    s_tv = tx_valid;
    s_to = timeout_pulse;
    s_data = tx_data;
    s_xfer = tx_valid && tx_ready;
    acc = req_valid & req_ready;
    if (s_xfer) obs.push_back({grant, tx_data});
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) if (acc[i]) void'(pq[i].pop_front());
  endtask

  function automatic bit pending();
    for (int i = 0; i < N; i++) if (pq[i].size() > 0) return 1'b1;
    return 1'b0;
  endfunction

  // expected byte stream: whole messages, next requester = first non-empty at or after the pointer
  function automatic void model();
    logic [DW:0] m [N][$];
    logic [DW:0] e;
    int sel;
    for (int i = 0; i < N; i++) m[i] = pq[i];
    for (int guard = 0; guard < 256; guard++) begin
      sel = -1;
      for (int k = 0; k < N; k++) begin
        if (m[(mptr + k) % N].size() > 0) begin
          sel = (mptr + k) % N;
          break;
        end
      end
      if (sel < 0) break;
      e = '0;
      while (!e[DW] && m[sel].size() > 0) begin
        e = m[sel].pop_front();
        exp_q.push_back({N'(1) << sel, e[DW-1:0]});
      end
      mptr = (sel + 1) % N;
    end
  endfunction

  task automatic run(input int pct, output bit to);
    int n = 0;
    while (n < 1000 && (pending() || busy)) begin
      tx_ready = $urandom_range(0, 99) < pct;
      step();
      n++;
    end
    to = n >= 1000;
  endtask

  task automatic reset_dut();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    obs.delete();
    mptr = 0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    pq[2].push_back({1'b1, 8'h55});
    step();
    step();
    total++; if (s_grant !== '0) $display("FAIL reset_grant got %b want 0000", s_grant); else passed++;
    total++; if (s_busy !== 1'b0) $display("FAIL reset_busy got %b want 0", s_busy); else passed++;
    total++; if (s_tv !== 1'b0) $display("FAIL reset_tx_valid got %b want 0", s_tv); else passed++;
    total++; if (s_ready !== '0) $display("FAIL reset_req_ready got %b want 0000", s_ready); else passed++;
    total++; if (s_to !== 1'b0) $display("FAIL reset_timeout got %b want 0", s_to); else passed++;
    pq[2].delete();
    step();
    reset = 1'b0;
    obs.delete();
    mptr = 0;
  endtask

  task automatic test_single();
    logic [N-1:0] eg;
    pq[0].push_back(9'h04F);
    pq[0].push_back(9'h06B);
    pq[0].push_back(9'h10A);
    obs.delete();
    exp_q.delete();
    exp_q.push_back({4'b0001, 8'h4F});
    exp_q.push_back({4'b0001, 8'h6B});
    exp_q.push_back({4'b0001, 8'h0A});
    for (int n = 0; n < 35; n++) begin
      tx_ready = n % 10 == 9;
      step();
      eg = (n >= 1 && n <= 29) ? 4'b0001 : 4'b0000;
      total++; if (s_grant !== eg) $display("FAIL single_grant[%0d] got %b want %b", n, s_grant, eg); else passed++;
      total++; if (s_busy !== |eg) $display("FAIL single_busy[%0d] got %b want %b", n, s_busy, |eg); else passed++;
    end
    total++; if (obs.size() != exp_q.size()) $display("FAIL single_len got %0d want %0d", obs.size(), exp_q.size()); else passed++;
    foreach (exp_q[j]) if (j < obs.size()) begin
      total++; if (obs[j] !== exp_q[j]) $display("FAIL single_byte[%0d] got %h want %h", j, obs[j], exp_q[j]); else passed++;
    end
    mptr = 1;
  endtask

  task automatic test_two();
    bit to;
    reset_dut();
    pq[1].push_back(9'h011);
    pq[1].push_back(9'h112);
    pq[2].push_back(9'h021);
    pq[2].push_back(9'h122);
    exp_q.delete();
    model();
    run(50, to);
    total++; if (to) $display("FAIL two_done got timeout want drained"); else passed++;
    for (int i = 0; i < N; i++) pq[i].push_back({1'b1, DW'(8'h30 + i)});
    model();
    run(50, to);
    total++; if (to) $display("FAIL two_wrap_done got timeout want drained"); else passed++;
    total++; if (obs.size() != exp_q.size()) $display("FAIL two_len got %0d want %0d", obs.size(), exp_q.size()); else passed++;
    foreach (exp_q[j]) if (j < obs.size()) begin
      total++; if (obs[j] !== exp_q[j]) $display("FAIL two_byte[%0d] got %h want %h", j, obs[j], exp_q[j]); else passed++;
    end
  endtask

  task automatic test_hold();
    bit pushed = 1'b0;
    bit r0;
    obs.delete();
    exp_q.delete();
    for (int b = 0; b < 4; b++) begin
      pq[0].push_back({b == 3, DW'(8'hA0 + b)});
      exp_q.push_back({4'b0001, DW'(8'hA0 + b)});
    end
    exp_q.push_back({4'b1000, 8'hB0});
    exp_q.push_back({4'b1000, 8'hB1});
    for (int n = 0; n < 100 && (pending() || busy); n++) begin
      if (!pushed && obs.size() == 2) begin
        pq[3].push_back(9'h0B0);
        pq[3].push_back(9'h1B1);
        pushed = 1'b1;
      end
      r0 = pq[0].size() > 0;
      tx_ready = n % 2 == 1;
      step();
      if (pushed && r0) begin
        total++; if (s_ready[3] !== 1'b0 || s_grant[3] !== 1'b0) $display("FAIL hold_req3[%0d] got ready=%b grant=%b want both 0", n, s_ready[3], s_grant[3]); else passed++;
      end
    end
    total++; if (pending() || busy) $display("FAIL hold_done got pending want drained"); else passed++;
    total++; if (obs.size() != exp_q.size()) $display("FAIL hold_len got %0d want %0d", obs.size(), exp_q.size()); else passed++;
    foreach (exp_q[j]) if (j < obs.size()) begin
      total++; if (obs[j] !== exp_q[j]) $display("FAIL hold_byte[%0d] got %h want %h", j, obs[j], exp_q[j]); else passed++;
    end
    mptr = 0;
  endtask

  task automatic test_timeout();
    logic [N-1:0] eg;
    reset_dut();
    pq[2].push_back(9'h0C2);
    pq[3].push_back(9'h1D3);
    exp_q.delete();
    exp_q.push_back({4'b0100, 8'hC2});
    exp_q.push_back({4'b1000, 8'hD3});
    tx_ready = 1'b1;
    for (int n = 0; n <= 20; n++) begin
      step();
      eg = n == 0 ? 4'b0000 : n <= 17 ? 4'b0100 : n == 19 ? 4'b1000 : 4'b0000;
      total++; if (s_grant !== eg) $display("FAIL timeout_grant[%0d] got %b want %b", n, s_grant, eg); else passed++;
      total++; if (s_to !== (n == 18)) $display("FAIL timeout_pulse[%0d] got %b want %b", n, s_to, n == 18); else passed++;
    end
    total++; if (obs.size() != exp_q.size()) $display("FAIL timeout_len got %0d want %0d", obs.size(), exp_q.size()); else passed++;
    foreach (exp_q[j]) if (j < obs.size()) begin
      total++; if (obs[j] !== exp_q[j]) $display("FAIL timeout_byte[%0d] got %h want %h", j, obs[j], exp_q[j]); else passed++;
    end
    mptr = 0;
  endtask

  task automatic test_rr_wrap();
    bit to;
    obs.delete();
    exp_q.delete();
    for (int j = 0; j < 2; j++)
      for (int i = 0; i < N; i++) pq[i].push_back({1'b1, DW'(8'h40 + 16 * j + i)});
    model();
    run(100, to);
    total++; if (to) $display("FAIL rr_done got timeout want drained"); else passed++;
    total++; if (obs.size() != exp_q.size()) $display("FAIL rr_len got %0d want %0d", obs.size(), exp_q.size()); else passed++;
    foreach (exp_q[j]) if (j < obs.size()) begin
      total++; if (obs[j] !== exp_q[j]) $display("FAIL rr_byte[%0d] got %h want %h", j, obs[j], exp_q[j]); else passed++;
    end
  endtask

  task automatic test_reset_mid();
    bit to;
    int n = 0;
    pq[1].push_back(9'h1E0);
    exp_q.delete();
    model();
    run(100, to);
    total++; if (to) $display("FAIL rmid_pre got timeout want drained"); else passed++;
    for (int b = 0; b < 5; b++) pq[1].push_back({b == 4, DW'(8'hF0 + b)});
    tx_ready = 1'b1;
    obs.delete();
    while (obs.size() < 2 && n < 50) begin
      step();
      n++;
    end
    reset = 1'b1;
    step();
    pq[3].push_back(9'h133);
    reset = 1'b0;
    obs.delete();
    step();
    total++; if (s_grant !== '0) $display("FAIL rmid_grant got %b want 0000", s_grant); else passed++;
    total++; if (s_tv !== 1'b0) $display("FAIL rmid_tx_valid got %b want 0", s_tv); else passed++;
    total++; if (s_ready !== '0) $display("FAIL rmid_req_ready got %b want 0000", s_ready); else passed++;
    step();
    total++; if (s_grant !== 4'b0010) $display("FAIL rmid_regrant got %b want 0010", s_grant); else passed++;
    total++; if (s_tv !== 1'b1 || s_data !== 8'hF3) $display("FAIL rmid_first got v=%b d=%h want v=1 d=f3", s_tv, s_data); else passed++;
    run(100, to);
    exp_q.delete();
    exp_q.push_back({4'b0010, 8'hF3});
    exp_q.push_back({4'b0010, 8'hF4});
    exp_q.push_back({4'b1000, 8'h33});
    total++; if (to) $display("FAIL rmid_done got timeout want drained"); else passed++;
    total++; if (obs.size() != exp_q.size()) $display("FAIL rmid_len got %0d want %0d", obs.size(), exp_q.size()); else passed++;
    foreach (exp_q[j]) if (j < obs.size()) begin
      total++; if (obs[j] !== exp_q[j]) $display("FAIL rmid_byte[%0d] got %h want %h", j, obs[j], exp_q[j]); else passed++;
    end
    mptr = 0;
  endtask

  task automatic test_random();
    int len, n;
    for (int r = 0; r < 4; r++) begin
      obs.delete();
      exp_q.delete();
      for (int i = 0; i < N; i++)
        for (int m = $urandom_range(0, 3); m > 0; m--) begin
          len = $urandom_range(1, 4);
          for (int b = 0; b < len; b++) pq[i].push_back({b == len - 1, DW'($urandom_range(0, 255))});
        end
      model();
      n = 0;
      while (n < 3000 && (pending() || busy)) begin
        tx_ready = $urandom_range(0, 99) < 60;
        step();
        n++;
        total++; if (!$onehot0(s_grant)) $display("FAIL rand_onehot got %b want one-hot or zero", s_grant); else passed++;
        total++; if ((s_ready & ~s_grant) !== '0) $display("FAIL rand_ready got ready=%b grant=%b want ready within grant", s_ready, s_grant); else passed++;
      end
      total++; if (n >= 3000) $display("FAIL rand_done[%0d] got timeout want drained", r); else passed++;
      total++; if (obs.size() != exp_q.size()) $display("FAIL rand_len[%0d] got %0d want %0d", r, obs.size(), exp_q.size()); else passed++;
      foreach (exp_q[j]) if (j < obs.size()) begin
        total++; if (obs[j] !== exp_q[j]) $display("FAIL rand_byte[%0d][%0d] got %h want %h", r, j, obs[j], exp_q[j]); else passed++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_two();
    test_hold();
    test_timeout();
    test_rr_wrap();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
